// File: rtl/cache_control.sv
// Control FSM for a 2-way set-associative, write-back, write-allocate, 1-bit-LRU cache.
// Optional performance counters are enabled by defining CACHE_PERF_CNT_EN.

package dimux;
    typedef enum logic {
        mem_wdata256_from_cpu = 1'b0,
        line_o_from_memory    = 1'b1
    } dimux_sel_t;
endpackage

package domux;
    typedef enum logic {
        data_array_0 = 1'b0,
        data_array_1 = 1'b1
    } domux_sel_t;
endpackage

package wemux;
    typedef enum logic [1:0] {
        zeros                       = 2'b00,
        ones                        = 2'b01,
        mem_byte_enable256_from_cpu = 2'b10
    } wemux_sel_t;
endpackage

package addrmux;
    typedef enum logic [1:0] {
        mem_address_from_cpu = 2'b00,
        cache_0              = 2'b01,
        cache_1              = 2'b10
    } addrmux_sel_t;
endpackage

module cache_control #(
    parameter int PERF_W = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    // CPU side
    input  logic                         mem_read,
    input  logic                         mem_write,
    output logic                         mem_resp,
    // cacheline adaptor side
    output logic                         pmem_read,
    output logic                         pmem_write,
    input  logic                         pmem_resp,
    // datapath status
    input  logic                         lru_o,
    input  logic [1:0]                   valid_o,
    input  logic [1:0]                   dirty_o,
    input  logic [1:0]                   cmp_o,
    // datapath control
    output dimux::dimux_sel_t            dimux_sel,
    output domux::domux_sel_t            domux_sel,
    output wemux::wemux_sel_t [1:0]      wemux_sel,
    output addrmux::addrmux_sel_t        addrmux_sel,
    output logic                         lru_load,
    output logic                         lru_i,
    output logic [1:0]                   valid_load,
    output logic [1:0]                   valid_i,
    output logic [1:0]                   dirty_load,
    output logic [1:0]                   dirty_i,
    output logic [1:0]                   tag_load,
    // debug / performance
    output logic [1:0]                   state_dbg,
    output logic [PERF_W-1:0]            hit_count,
    output logic [PERF_W-1:0]            miss_count,
    output logic [PERF_W-1:0]            wb_count
);

    // Handshakes: the CPU holds mem_read/mem_write (and address/data) until
    // mem_resp pulses for one cycle; pmem_read/pmem_write are held until the
    // adaptor pulses pmem_resp for one cycle, which ends the transfer.

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        CHECK     = 2'd1,
        WRITEBACK = 2'd2,
        FILL      = 2'd3
    } state_t;

    state_t state, state_next;
    logic   victim, victim_next;

    logic       req;
    logic       is_write;
    logic [1:0] hit;
    logic       hit_any;
    logic       hit_way;
    logic       victim_dirty;

    assign req          = mem_read | mem_write;
    assign is_write     = mem_write;
    assign hit          = valid_o & cmp_o;
    assign hit_any      = |hit;
    assign hit_way      = hit[1] & ~hit[0];
    assign victim_dirty = valid_o[lru_o] & dirty_o[lru_o];
    assign state_dbg    = state;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            victim <= 1'b0;
        end else begin
            state  <= state_next;
            victim <= victim_next;
        end
    end

    always_comb begin
        state_next   = state;
        victim_next  = victim;
        mem_resp     = 1'b0;
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        dimux_sel    = dimux::mem_wdata256_from_cpu;
        domux_sel    = domux::data_array_0;
        wemux_sel[0] = wemux::zeros;
        wemux_sel[1] = wemux::zeros;
        addrmux_sel  = addrmux::mem_address_from_cpu;
        lru_load     = 1'b0;
        lru_i        = 1'b0;
        valid_load   = 2'b00;
        valid_i      = 2'b00;
        dirty_load   = 2'b00;
        dirty_i      = 2'b00;
        tag_load     = 2'b00;

        case (state)
            IDLE: begin
                if (req) state_next = CHECK;
            end

            CHECK: begin
                if (hit_any) begin
                    mem_resp  = 1'b1;
                    domux_sel = domux::domux_sel_t'(hit_way);
                    lru_load  = 1'b1;
                    lru_i     = ~hit_way;
                    if (is_write) begin
                        dimux_sel           = dimux::mem_wdata256_from_cpu;
                        wemux_sel[hit_way]  = wemux::mem_byte_enable256_from_cpu;
                        dirty_load[hit_way] = 1'b1;
                        dirty_i[hit_way]    = 1'b1;
                    end
                    state_next = IDLE;
                end else begin
                    // The LRU bit names the way to evict; it is frozen here for the whole miss.
                    victim_next = lru_o;
                    state_next  = victim_dirty ? WRITEBACK : FILL;
                end
            end

            WRITEBACK: begin
                pmem_write  = 1'b1;
                addrmux_sel = victim ? addrmux::cache_1 : addrmux::cache_0;
                domux_sel   = domux::domux_sel_t'(victim);
                if (pmem_resp) state_next = FILL;
            end

            FILL: begin
                pmem_read   = 1'b1;
                addrmux_sel = addrmux::mem_address_from_cpu;
                dimux_sel   = dimux::line_o_from_memory;
                if (pmem_resp) begin
                    wemux_sel[victim]  = wemux::ones;
                    tag_load[victim]   = 1'b1;
                    valid_load[victim] = 1'b1;
                    valid_i[victim]    = 1'b1;
                    dirty_load[victim] = 1'b1;
                    dirty_i[victim]    = 1'b0;
                    state_next         = CHECK;
                end
            end

            default: state_next = IDLE;
        endcase
    end

`ifdef CACHE_PERF_CNT_EN
    logic              prev_idle;
    logic [PERF_W-1:0] hit_cnt_q;
    logic [PERF_W-1:0] miss_cnt_q;
    logic [PERF_W-1:0] wb_cnt_q;

    // Only first-pass hits count; the re-check after a fill follows FILL, not IDLE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prev_idle  <= 1'b0;
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
            wb_cnt_q   <= '0;
        end else begin
            prev_idle <= (state == IDLE);
            if (state == CHECK && hit_any && prev_idle && hit_cnt_q != {PERF_W{1'b1}})
                hit_cnt_q <= hit_cnt_q + PERF_W'(1);
            if (state == CHECK && !hit_any && miss_cnt_q != {PERF_W{1'b1}})
                miss_cnt_q <= miss_cnt_q + PERF_W'(1);
            if (state == WRITEBACK && pmem_resp && wb_cnt_q != {PERF_W{1'b1}})
                wb_cnt_q <= wb_cnt_q + PERF_W'(1);
        end
    end

    assign hit_count  = hit_cnt_q;
    assign miss_count = miss_cnt_q;
    assign wb_count   = wb_cnt_q;
`else
    assign hit_count  = '0;
    assign miss_count = '0;
    assign wb_count   = '0;
`endif

endmodule

// File: tb/tb_cache_control.sv
// Randomized self-checking bench for cache_control: emulates the tag/valid/dirty/LRU
// arrays from the DUT's load strobes and checks them against a transaction-level cache model.

module tb_cache_control;

    localparam int PERF_W = 32;
    localparam logic [1:0] AM_CPU   = addrmux::mem_address_from_cpu;
    localparam logic       DIM_CPU  = dimux::mem_wdata256_from_cpu;
    localparam logic       DIM_LINE = dimux::line_o_from_memory;
    localparam logic [1:0] WE_ONES  = wemux::ones;
    localparam logic [1:0] WE_BE    = wemux::mem_byte_enable256_from_cpu;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic mem_read = 1'b0, mem_write = 1'b0, pmem_resp = 1'b0;
    logic mem_resp, pmem_read, pmem_write, lru_o;
    logic [1:0] valid_o, dirty_o, cmp_o;
    dimux::dimux_sel_t       dimux_sel;
    domux::domux_sel_t       domux_sel;
    wemux::wemux_sel_t [1:0] wemux_sel;
    addrmux::addrmux_sel_t   addrmux_sel;
    logic lru_load, lru_i;
    logic [1:0] valid_load, valid_i, dirty_load, dirty_i, tag_load, state_dbg;
    logic [PERF_W-1:0] hit_count, miss_count, wb_count;

    // datapath arrays as the DUT's load strobes leave them
    logic [1:0] dp_valid[4], dp_dirty[4];
    logic       dp_lru[4];
    logic [3:0] dp_tag[4][2];
    // reference cache model
    logic [1:0] rf_valid[4], rf_dirty[4];
    logic       rf_lru[4];
    logic [3:0] rf_tag[4][2];
    int rf_hits = 0, rf_misses = 0, rf_wbs = 0;

    logic [1:0] cur_set = 2'd0;
    logic [3:0] cur_tag = 4'd0;

    logic       p_lru_load = 1'b0, p_lru_i = 1'b0;
    logic [1:0] p_valid_load = '0, p_valid_i = '0, p_dirty_load = '0, p_dirty_i = '0, p_tag_load = '0;

    logic [22:0] exp_q[$];
    int n_checks = 0;
    int n_errors = 0;

    assign valid_o = dp_valid[cur_set];
    assign dirty_o = dp_dirty[cur_set];
    assign lru_o   = dp_lru[cur_set];
    assign cmp_o   = {dp_tag[cur_set][1] == cur_tag, dp_tag[cur_set][0] == cur_tag};

    cache_control #(.PERF_W(PERF_W)) dut (
        .clk(clk), .rst(rst),
        .mem_read(mem_read), .mem_write(mem_write), .mem_resp(mem_resp),
        .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_resp(pmem_resp),
        .lru_o(lru_o), .valid_o(valid_o), .dirty_o(dirty_o), .cmp_o(cmp_o),
        .dimux_sel(dimux_sel), .domux_sel(domux_sel), .wemux_sel(wemux_sel),
        .addrmux_sel(addrmux_sel), .lru_load(lru_load), .lru_i(lru_i),
        .valid_load(valid_load), .valid_i(valid_i), .dirty_load(dirty_load),
        .dirty_i(dirty_i), .tag_load(tag_load), .state_dbg(state_dbg),
        .hit_count(hit_count), .miss_count(miss_count), .wb_count(wb_count)
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [22:0] snap();
        return {addrmux_sel, domux_sel, dimux_sel, pmem_read, pmem_write, mem_resp, tag_load,
                valid_load, valid_i, dirty_load, dirty_i, wemux_sel, lru_load, lru_i};
    endfunction

    function automatic logic [22:0] mk(input logic [1:0] am, input logic dom, input logic dim,
                                       input logic pr, input logic pw, input logic mr,
                                       input logic [1:0] tl, input logic [1:0] vl, input logic [1:0] vi,
                                       input logic [1:0] dl, input logic [1:0] di,
                                       input logic [3:0] we, input logic ll, input logic li);
        return {am, dom, dim, pr, pw, mr, tl, vl, vi, dl, di, we, ll, li};
    endfunction

    task automatic capture_pending();
        p_lru_load = lru_load;     p_lru_i = lru_i;
        p_valid_load = valid_load; p_valid_i = valid_i;
        p_dirty_load = dirty_load; p_dirty_i = dirty_i;
        p_tag_load = tag_load;
    endtask

    task automatic apply_pending();
        for (int w = 0; w < 2; w++) begin
            if (p_tag_load[w])   dp_tag[cur_set][w]   = cur_tag;
            if (p_valid_load[w]) dp_valid[cur_set][w] = p_valid_i[w];
            if (p_dirty_load[w]) dp_dirty[cur_set][w] = p_dirty_i[w];
        end
        if (p_lru_load) dp_lru[cur_set] = p_lru_i;
        p_lru_load = 1'b0; p_valid_load = '0; p_dirty_load = '0; p_tag_load = '0;
    endtask

    task automatic preset(input logic [1:0] s, input logic [1:0] v, input logic [1:0] d,
                          input logic l, input logic [3:0] t0, input logic [3:0] t1);
        dp_valid[s] = v;  rf_valid[s] = v;
        dp_dirty[s] = d;  rf_dirty[s] = d;
        dp_lru[s] = l;    rf_lru[s] = l;
        dp_tag[s][0] = t0; rf_tag[s][0] = t0;
        dp_tag[s][1] = t1; rf_tag[s][1] = t1;
    endtask

    task automatic check_set(input logic [1:0] s);
        check_val("array_state",
                  {dp_valid[s], dp_dirty[s], dp_lru[s], dp_tag[s][1], dp_tag[s][0]},
                  {rf_valid[s], rf_dirty[s], rf_lru[s], rf_tag[s][1], rf_tag[s][0]});
    endtask

    // driver: one CPU request, with the cacheline adaptor answering after d_wb / d_fill cycles
    task automatic do_req(input logic [1:0] s, input logic [3:0] t, input bit wr,
                          input int d_wb, input int d_fill);
        bit h0, h1, hit, hw, wb, got;
        int n, wb_n, fill_n, wb_bad, both_bad, exp_lat;
        logic [1:0] oh;
        logic [3:0] we;
        logic [22:0] exp_ev;
        addrmux::addrmux_sel_t wb_am;

        h0 = rf_valid[s][0] && rf_tag[s][0] == t;
        h1 = rf_valid[s][1] && rf_tag[s][1] == t;
        hit = h0 || h1;
        wb = 1'b0;
        if (hit) begin
            hw = h0 ? 1'b0 : 1'b1;
            rf_hits++;
        end else begin
            hw = rf_lru[s];
            wb = rf_valid[s][hw] && rf_dirty[s][hw];
            rf_misses++;
            if (wb) rf_wbs++;
            rf_tag[s][hw] = t; rf_valid[s][hw] = 1'b1; rf_dirty[s][hw] = 1'b0;
            oh = 2'b01 << hw;
            we = '0; we[2*hw +: 2] = WE_ONES;
            exp_q.push_back(mk(AM_CPU, 1'b0, DIM_LINE, 1'b1, 1'b0, 1'b0, oh, oh, oh, oh, 2'b00, we, 1'b0, 1'b0));
        end
        rf_lru[s] = ~hw;
        oh = 2'b01 << hw;
        we = '0;
        if (wr) begin
            rf_dirty[s][hw] = 1'b1;
            we[2*hw +: 2] = WE_BE;
        end
        exp_q.push_back(mk(AM_CPU, hw, DIM_CPU, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00,
                           wr ? oh : 2'b00, wr ? oh : 2'b00, we, 1'b1, ~hw));
        exp_lat = hit ? 2 : 3 + (wb ? d_wb : 0) + d_fill;
        wb_am = hw ? addrmux::cache_1 : addrmux::cache_0;

        cur_set = s; cur_tag = t;
        mem_write = wr;
        mem_read = wr ? 1'($urandom_range(0, 1)) : 1'b1;
        n = 1; got = 1'b0; wb_n = 0; fill_n = 0; wb_bad = 0; both_bad = 0;
        while (!got && n < 80) begin
            @(posedge clk); #1; apply_pending();
            @(negedge clk); n++;
            pmem_resp = 1'b0;
            if (pmem_write) begin
                wb_n++;
                if (wb_n == d_wb) pmem_resp = 1'b1;
                if (addrmux_sel != wb_am || domux_sel != domux::domux_sel_t'(hw)) wb_bad++;
            end
            if (pmem_read) begin
                fill_n++;
                if (fill_n == d_fill) pmem_resp = 1'b1;
            end
            if (pmem_read && pmem_write) both_bad++;
            #1;
            capture_pending();
            if (n == 2) check_val("state_check", state_dbg, 32'd1);
            if ((pmem_read && pmem_resp) || mem_resp) begin
                exp_ev = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
                check_val(mem_resp ? "resp_outputs" : "fill_outputs", snap(), exp_ev);
                if (mem_resp) got = 1'b1;
            end
        end
        check_val("latency", n, exp_lat);
        check_val("wb_cycles", wb_n, wb ? d_wb : 0);
        check_val("fill_cycles", fill_n, hit ? 0 : d_fill);
        check_val("wb_addr_way", wb_bad, 0);
        check_val("pmem_excl", both_bad, 0);
        @(posedge clk); #1; apply_pending();
        mem_read = 1'b0; mem_write = 1'b0; pmem_resp = 1'b0;
        check_val("sb_drain", exp_q.size(), 0);
        exp_q.delete();
        check_set(s);
        @(negedge clk);
    endtask

    initial begin
        int k;
        logic [5:0] pat;
        for (int s = 0; s < 4; s++) preset(2'(s), 2'b00, 2'b00, 1'b0, 4'd0, 4'd0);

        // reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("reset_outputs", snap(),
                  mk(AM_CPU, 1'b0, DIM_CPU, 1'b0, 1'b0, 1'b0, '0, '0, '0, '0, '0, 4'h0, 1'b0, 1'b0));
        check_val("reset_state", state_dbg, 32'd0);
        check_val("reset_cnt", hit_count | miss_count | wb_count, 32'd0);
        rst = 1'b1;

        // stray pmem_resp in IDLE is ignored
        @(negedge clk);
        pmem_resp = 1'b1;
        @(posedge clk); #1;
        check_val("idle_pmem_resp", {state_dbg, pmem_read, pmem_write, mem_resp, tag_load, valid_load}, 32'd0);
        @(negedge clk);
        pmem_resp = 1'b0;

        // asynchronous reset in the middle of a fill
        cur_set = 2'd3; cur_tag = 4'd9; mem_read = 1'b1;
        k = 0;
        while (!pmem_read && k < 10) begin
            @(negedge clk); k++;
        end
        check_val("fill_reached", pmem_read, 32'd1);
        #2 rst = 1'b0;
        #1;
        check_val("rst_abort", {pmem_read, pmem_write, tag_load, valid_load, dirty_load, state_dbg}, 32'd0);
        mem_read = 1'b0;
        @(negedge clk);
        check_set(2'd3);
        check_val("rst_hit_cnt", hit_count, 32'd0);
        check_val("rst_miss_cnt", miss_count, 32'd0);
        rst = 1'b1;
        rf_hits = 0; rf_misses = 0; rf_wbs = 0;

        // cold read set 3 after the reset: fill way 0, then hit
        do_req(2'd3, 4'd9, 1'b0, 0, 2);
        // read hit way 1
        preset(2'd1, 2'b10, 2'b00, 1'b0, 4'd3, 4'd7);
        do_req(2'd1, 4'd7, 1'b0, 0, 1);
        // write hit way 0
        preset(2'd2, 2'b01, 2'b00, 1'b1, 4'd4, 4'd4);
        do_req(2'd2, 4'd4, 1'b1, 0, 1);
        // dirty miss on way 1 with a slow writeback
        preset(2'd0, 2'b11, 2'b10, 1'b1, 4'd1, 4'd2);
        do_req(2'd0, 4'd3, 1'b0, 5, 3);

        // back-to-back hits: IDLE for exactly one cycle between responses
        preset(2'd1, 2'b01, 2'b00, 1'b0, 4'd2, 4'd6);
        cur_set = 2'd1; cur_tag = 4'd2; mem_read = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1; apply_pending();
            @(negedge clk); #1; capture_pending();
            pat[i] = mem_resp;
        end
        mem_read = 1'b0;
        @(posedge clk); #1; apply_pending();
        rf_lru[1] = 1'b1; rf_hits += 3;
        check_val("b2b_pattern", pat, 32'b010101);
        check_set(2'd1);
        @(negedge clk);

        // randomized traffic over a small set/tag space
        for (int i = 0; i < 40; i++)
            do_req(2'($urandom_range(0, 3)), 4'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                   int'($urandom_range(1, 4)), int'($urandom_range(1, 4)));

`ifdef CACHE_PERF_CNT_EN
        check_val("hit_count", hit_count, rf_hits);
        check_val("miss_count", miss_count, rf_misses);
        check_val("wb_count", wb_count, rf_wbs);
`else
        check_val("hit_count", hit_count, 32'd0);
        check_val("miss_count", miss_count, 32'd0);
        check_val("wb_count", wb_count, 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
